axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream output channel among NUM_PORTS AXI-Stream requesters. A grant is held for a whole packet, from the first beat through the beat carrying tlast. Beats pass through one internal register stage with the same ready rule as the team's AXI-Stream register slice, so the output is fully registered. It sits in front of a shared downstream stream resource: a register slice, FIFO or DMA write channel.

## Interface
- DATA_WIDTH, 32, tdata width per port in bits.
- NUM_PORTS, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NUM_PORTS), width of grant_id (derived; not overridden).
- clk  input  1  clock; all state on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- s_axis_tdata  input  NUM_PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  input  NUM_PORTS  per-port valid.
- s_axis_tready  output  NUM_PORTS  per-port ready; at most one bit high.
- s_axis_tlast  input  NUM_PORTS  per-port end-of-packet.
- m_axis_tdata  output  DATA_WIDTH  registered output data.
- m_axis_tvalid  output  1  registered output valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  registered output last.
- grant_valid  output  1  high while a packet grant is held (state GRANTED).
- grant_id  output  IDW  index of the granted port; holds the last granted index when grant_valid is 0.

## Operation
- FSM with two states: IDLE and GRANTED.
- IDLE:
  - s_axis_tready is all zero.
  - If any s_axis_tvalid is high, select the first requesting port scanning from (last_grant+1) mod NUM_PORTS upward with wrap-around.
  - Register the selection into grant_id and go to GRANTED on the next edge.
  - If no port requests, stay in IDLE.
- GRANTED:
  - s_axis_tready[grant_id] = slot_ready; all other ready bits are 0.
  - slot_ready = !m_axis_tvalid | m_axis_tready.
  - A beat is accepted when s_axis_tvalid[grant_id] & slot_ready.
  - On an accepted beat, load tdata and tlast of the granted port into the output register and set m_axis_tvalid.
  - If the accepted beat has tlast=1: last_grant <= grant_id, and the state returns to IDLE on the same edge.
- Output register:
  - If m_axis_tvalid & m_axis_tready and no new beat is loaded, clear m_axis_tvalid.
  - tdata and tlast change only when a beat is loaded.
- The grant is never revoked mid-packet. If the granted requester drops tvalid, the grant is held indefinitely; there is no timeout.
- Requests from non-granted ports are ignored until the next IDLE cycle; no beat is lost or reordered.
- Round-robin fairness: after port k completes a packet, every other requesting port is served once before k is served again.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready=0, grant_valid=0, grant_id=NUM_PORTS-1.
  - last_grant=NUM_PORTS-1, so port 0 has first priority after reset.
  - State = IDLE.
- Reset asserted mid-packet: all of the above apply immediately. Any beat held in the output register is discarded, and the packet is truncated.
- Arbitration latency: tvalid rises in cycle 0 (IDLE) -> grant_valid=1 and tready high in cycle 1 -> first beat visible on m_axis in cycle 2, assuming no stall.
- Throughput inside a packet is 1 beat/cycle while m_axis_tready=1.
- Each packet boundary costs exactly one IDLE arbitration cycle, including single-beat packets.
- Downstream stall: with m_axis_tvalid=1 and m_axis_tready=0, slot_ready=0 and the granted tready is 0. The output register holds its value.
- Simultaneous last-beat acceptance and downstream drain in the same cycle is legal. The register reloads and m_axis_tvalid stays 1.
- The output register holds one beat after the FSM returns to IDLE and drains independently.
- s_axis_tready must not depend combinationally on any s_axis_tvalid. It depends only on state, grant_id, m_axis_tvalid and m_axis_tready.

## Test plan
- Single requester: port 2 sends a 3-beat packet A0..A2 (tlast on A2), m_axis_tready=1. Required: grant_id=2 in cycle 1; m_axis carries A0,A1,A2 in cycles 2-4 with tlast only on A2; grant_valid=0 in cycle 4.
- Contention: all 4 ports request 2-beat packets continuously from reset. Required: grant order 0,1,2,3,0; one bubble cycle between packets; no beats interleaved.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat packet. Required: while stalled, tready to the granted port is 0 and m_axis_tdata/tvalid stay stable; all 4 beats arrive in order with no duplicates.
- Mid-packet gap: the granted port 1 drops tvalid for 5 cycles inside a packet while port 3 requests. Required: the grant stays on 1 and s_axis_tready[3] stays 0; port 3 is granted only after port 1's tlast.
- Single-beat packets: ports 0 and 1 each send 1-beat packets back-to-back. Required: the output alternates 0,1,0,1 at one beat every 2 cycles.
- Reset mid-packet: assert reset during beat 2 of 4. Required: m_axis_tvalid=0 and grant_valid=0 immediately. After release, port 0 is granted first if requesting.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_PORTS AXI-Stream requesters share one
// registered AXI-Stream output. A grant is held from the first beat through tlast.
module axis_rr_arbiter #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_PORTS  = 4,
    localparam int IDW        = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            grant_valid,
    output logic [IDW-1:0]                  grant_id
);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IDW-1:0]        grant_next;
    logic [IDW-1:0]        last_grant;
    logic [IDW-1:0]        last_next;
    logic                  slot_ready;
    logic                  accept;
    logic [DATA_WIDTH-1:0] beat_data_p0;
    logic                  beat_last_p0;

    // First requester strictly after 'last', wrapping; only called when some bit of req is set.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [IDW-1:0]       last);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = last;
        found = 1'b0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            idx = int'(last) + off;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && req[idx]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign slot_ready   = !m_axis_tvalid || m_axis_tready;
    assign beat_data_p0 = s_axis_tdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign beat_last_p0 = s_axis_tlast[grant_id];
    assign grant_valid  = (state == GRANTED);

    // Ready is built from state and the output slot only, never from any tvalid.
    always_comb begin
        state_next    = state;
        grant_next    = grant_id;
        last_next     = last_grant;
        s_axis_tready = '0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_next = rr_pick(s_axis_tvalid, last_grant);
                    state_next = GRANTED;
                end
            end
            GRANTED: begin
                s_axis_tready[grant_id] = slot_ready;
                accept = s_axis_tvalid[grant_id] && slot_ready;
                if (accept && s_axis_tlast[grant_id]) begin
                    last_next  = grant_id;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stage p0 -> p1: the granted beat lands in the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant_id      <= IDW'(NUM_PORTS - 1);
            last_grant    <= IDW'(NUM_PORTS - 1);
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state      <= state_next;
            grant_id   <= grant_next;
            last_grant <= last_next;
            if (accept) begin
                m_axis_tdata  <= beat_data_p0;
                m_axis_tlast  <= beat_last_p0;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomised bench for axis_rr_arbiter: per-port packet drivers, a packet-level
// arbitration model and an output scoreboard fed by the model.
module tb_axis_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;

    logic              clk;
    logic              reset;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tready;
    logic [NP-1:0]     s_axis_tlast;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              grant_valid;
    logic [1:0]        grant_id;

    axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver configuration, written by the main process.
    logic [NP-1:0] en_mask = '0;
    int min_len = 1, max_len = 1, gap_pct = 0, rdy_pct = 100, start_pct = 100;

    // Driver state
    int        pkts_left[NP];
    bit        active[NP];
    int        plen[NP];
    int        beat[NP];
    int        pseq[NP];
    bit        vld[NP];
    logic [NP-1:0] acc_v = '0;

    // Reference model state
    bit         m_gr;
    int         m_gid, m_last;
    bit         m_mv;
    logic [DW:0] exp_q[$];
    int         glog[$];
    bit         prev_stall, prev_gv;
    logic [DW:0] prev_beat;

    // Drivers: update 1 time unit after each rising edge.
    initial begin
        for (int i = 0; i < NP; i++) begin
            pkts_left[i] = 0; active[i] = 0; plen[i] = 1; beat[i] = 0; pseq[i] = 0; vld[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                for (int i = 0; i < NP; i++) begin
                    pkts_left[i] = 0; active[i] = 0; beat[i] = 0; vld[i] = 0;
                end
                s_axis_tvalid = '0;
                s_axis_tlast  = '0;
                m_axis_tready = 1'b1;
            end else begin
                m_axis_tready = ($urandom_range(99) < rdy_pct);
                for (int i = 0; i < NP; i++) begin
                    if (acc_v[i]) begin
                        beat[i]++;
                        vld[i] = 0;
                        if (beat[i] == plen[i]) active[i] = 0;
                    end
                    if (!active[i] && en_mask[i] && pkts_left[i] > 0 &&
                        $urandom_range(99) < start_pct) begin
                        active[i] = 1;
                        plen[i]   = $urandom_range(max_len, min_len);
                        beat[i]   = 0;
                        pseq[i]++;
                        pkts_left[i]--;
                    end
                    if (active[i] && !vld[i])
                        vld[i] = (beat[i] == 0) || ($urandom_range(99) >= gap_pct);
                    s_axis_tvalid[i] = vld[i];
                    s_axis_tlast[i]  = active[i] && (beat[i] == plen[i] - 1);
                    s_axis_tdata[i*DW +: DW] = {8'(i), 8'(pseq[i]), 16'(beat[i])};
                end
            end
        end
    end

    // Monitor and model: sample at the falling edge.
    initial begin
        int   pick;
        int   cand;
        bit   slot;
        bit   macc;
        logic [NP-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
                chk("rst_m_tdata", 64'(m_axis_tdata), 64'(0));
                chk("rst_m_tlast", 64'(m_axis_tlast), 64'(0));
                chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
                chk("rst_grant_valid", 64'(grant_valid), 64'(0));
                chk("rst_grant_id", 64'(grant_id), 64'(NP - 1));
                m_gr = 0; m_gid = NP - 1; m_last = NP - 1; m_mv = 0;
                exp_q.delete();
                acc_v = '0; prev_stall = 0; prev_gv = 0;
            end else begin
                slot    = !m_mv || m_axis_tready;
                exp_rdy = '0;
                if (m_gr && slot) exp_rdy[m_gid] = 1'b1;
                chk("grant_valid", 64'(grant_valid), 64'(m_gr));
                chk("grant_id", 64'(grant_id), 64'(m_gid));
                chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
                chk("m_tvalid", 64'(m_axis_tvalid), 64'(m_mv));
                if (prev_stall)
                    chk("stall_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                        64'({1'b1, prev_beat}));
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0)
                        chk("unexpected_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'hdead_beef_dead);
                    else
                        chk("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat  = {m_axis_tlast, m_axis_tdata};
                if (grant_valid && !prev_gv) glog.push_back(int'(grant_id));
                prev_gv = grant_valid;
                acc_v   = s_axis_tvalid & s_axis_tready;

                // Packet-level rules: the holder streams until tlast; an idle cycle
                // then picks the next requester after the previous holder.
                macc = 0;
                if (m_gr) begin
                    if (s_axis_tvalid[m_gid] && slot) begin
                        macc = 1;
                        exp_q.push_back({s_axis_tlast[m_gid], s_axis_tdata[m_gid*DW +: DW]});
                        if (s_axis_tlast[m_gid]) begin
                            m_last = m_gid;
                            m_gr   = 0;
                        end
                    end
                end else if (|s_axis_tvalid) begin
                    pick = -1;
                    for (int off = 1; off <= NP; off++) begin
                        cand = (m_last + off) % NP;
                        if (pick < 0 && s_axis_tvalid[cand]) pick = cand;
                    end
                    m_gid = pick;
                    m_gr  = 1;
                end
                m_mv = macc || (m_mv && !m_axis_tready);
            end
        end
    end

    function automatic bit all_done();
        for (int i = 0; i < NP; i++)
            if (pkts_left[i] != 0 || active[i]) return 0;
        return (exp_q.size() == 0) && !m_mv;
    endfunction

    task automatic run_phase(input string name, input logic [NP-1:0] mask, input int npk,
                             input int lmin, input int lmax, input int gap, input int rdy,
                             input int st);
        bit ok;
        @(posedge clk);
        #3;
        min_len = lmin; max_len = lmax; gap_pct = gap; rdy_pct = rdy; start_pct = st;
        glog.delete();
        for (int i = 0; i < NP; i++) pkts_left[i] = mask[i] ? npk : 0;
        en_mask = mask;
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #3;
            if (all_done()) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: packets not drained, expected drained within 3000 cycles", name);
        end
        en_mask = '0;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    int ord_cont[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int ord_single[6] = '{0, 1, 0, 1, 0, 1};
    bit hit;

    initial begin
        reset = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;

        run_phase("single_req", 4'b0100, 1, 3, 3, 0, 100, 100);
        chk("single_req_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'(2));

        do_reset(2);
        run_phase("contention", 4'b1111, 2, 2, 2, 0, 100, 100);
        chk("cont_count", 64'(glog.size()), 64'(8));
        for (int i = 0; i < 8; i++)
            if (i < glog.size()) chk("cont_order", 64'(glog[i]), 64'(ord_cont[i]));

        run_phase("single_beat", 4'b0011, 3, 1, 1, 0, 100, 100);
        chk("sbeat_count", 64'(glog.size()), 64'(6));
        for (int i = 0; i < 6; i++)
            if (i < glog.size()) chk("sbeat_order", 64'(glog[i]), 64'(ord_single[i]));

        run_phase("backpressure", 4'b0001, 4, 4, 4, 0, 50, 100);
        run_phase("gap", 4'b1010, 4, 3, 6, 60, 80, 100);
        run_phase("random", 4'b1111, 8, 1, 5, 20, 70, 50);

        // Reset while the third beat of a 4-beat packet is on offer.
        @(posedge clk);
        #3;
        min_len = 4; max_len = 4; gap_pct = 0; rdy_pct = 100; start_pct = 100;
        pkts_left[0] = 1;
        en_mask = 4'b0001;
        hit = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #3;
            if (active[0] && beat[0] == 2) begin
                hit = 1;
                break;
            end
        end
        chk("mid_pkt_reached", 64'(hit), 64'(1));
        reset = 1'b1;
        en_mask = '0;
        #1;
        chk("async_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("async_grant_valid", 64'(grant_valid), 64'(0));
        chk("async_s_tready", 64'(s_axis_tready), 64'(0));
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        run_phase("after_reset", 4'b0011, 1, 2, 3, 0, 100, 100);
        chk("after_reset_first", 64'(glog.size() > 0 ? glog[0] : -1), 64'(0));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
